audio_volume_ramp: RTL and testbench

//  Stereo master-volume / soft-mute stage between the output mux and pcm_to_i2s.
//  - Scales each 24-bit PCM sample by a shared 16-bit gain.
//  - Ramps the gain toward a CPU-set target once per stereo frame, so mute/volume changes never click.
//  - Saturates results to 24-bit signed; flags clipping in a status bit.

---
 rtl/audio_pkg.sv | 41 ++++
 rtl/vol_sat_mult.sv | 74 +++++++
 rtl/audio_volume_ramp.sv | 147 ++++++++++++++
 tb/tb_audio_volume_ramp.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants, state encoding and gain-ramp arithmetic for the master-volume stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package audio_pkg;

  localparam int DATA_W   = 24;
  localparam int GAIN_W   = 16;
  localparam int PIPE_LAT = 2;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h8000;
  localparam logic [DATA_W-1:0] PCM_MAX    = 24'h7FFFFF;
  localparam logic [DATA_W-1:0] PCM_MIN    = 24'h800000;

  typedef enum logic [1:0] {
    VR_MUTED  = 2'd0,
    VR_RAMP   = 2'd1,
    VR_STEADY = 2'd2
  } vr_state_e;

  // One ramp step toward tgt. Clamps at tgt in both directions, so the gain
  // can neither overshoot nor wrap. A zero step means jump straight to tgt.
  function automatic logic [GAIN_W-1:0] ramp_next(input logic [GAIN_W-1:0] gain,
                                                   input logic [GAIN_W-1:0] tgt,
                                                   input logic [GAIN_W-1:0] step);
    logic [GAIN_W:0]   sum;
    logic [GAIN_W-1:0] diff;
    logic [GAIN_W-1:0] res;
    sum  = {1'b0, gain} + {1'b0, step};
    diff = gain - tgt;
    res  = gain;
    if (step == '0) begin
      res = tgt;
    end else if (gain < tgt) begin
      res = (sum >= {1'b0, tgt}) ? tgt : sum[GAIN_W-1:0];
    end else if (gain > tgt) begin
      res = (diff <= step) ? tgt : gain - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/vol_sat_mult.sv
// One channel: signed sample x unsigned Q1.15 gain, shift by 15, saturate to 24-bit signed.
// Latency: 2 cycles from en to vld; dout holds until the next strobe.
// Backpressure: none; accepts a sample every cycle. run low flushes the pipe to zero.
// Ports: clk, reset_n (async active-low), run (sync clear when low), en/din (sample in),
//        gain (Q1.15), vld/dout (sample out), clip (saturation event, one cycle wide).
module vol_sat_mult
  import audio_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [GAIN_W-1:0] gain,
  output logic              vld,
  output logic [DATA_W-1:0] dout,
  output logic              clip
);

  logic signed [40:0] prod_q, prod_d;
  logic               v1_q, v1_d;
  logic               vld_q, vld_d;
  logic [DATA_W-1:0]  dout_q, dout_d;

  logic signed [40:0] shifted;
  logic               in_range;

  // Operands widened to the full product width so the multiply is exact.
  logic signed [40:0] din_ext;
  logic signed [40:0] gain_ext;

  always_comb begin
    din_ext  = $signed({{17{din[DATA_W-1]}}, din});
    gain_ext = $signed({25'd0, gain});
    shifted  = prod_q >>> 15;
    // Result fits 24-bit signed when bits 40..23 are all copies of the sign.
    in_range = (shifted[40:23] == {18{shifted[40]}});
  end

  always_comb begin
    prod_d = prod_q;
    v1_d   = 1'b0;
    vld_d  = 1'b0;
    dout_d = dout_q;
    if (!run) begin
      prod_d = '0;
      dout_d = '0;
    end else begin
      v1_d  = en;
      vld_d = v1_q;
      if (en) prod_d = din_ext * gain_ext;
      if (v1_q) dout_d = in_range ? shifted[DATA_W-1:0] : (shifted[40] ? PCM_MIN : PCM_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      v1_q   <= 1'b0;
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      prod_q <= prod_d;
      v1_q   <= v1_d;
      vld_q  <= vld_d;
      dout_q <= dout_d;
    end
  end

  assign vld  = vld_q;
  assign dout = dout_q;
  assign clip = run & v1_q & ~in_range;

endmodule

// File: rtl/audio_volume_ramp.sv
// Stereo master volume / soft mute: shared gain ramped once per frame (r_data_en) toward the CPU target.
// Latency: 2 cycles strobe-in to strobe-out per channel; gain moves only on run & r_data_en.
// Backpressure: none; both channels accept a sample every cycle, simultaneous strobes both processed.
// Ports: clk, reset_n, run, mute, volume, ramp_step, l/r_data_en, l/r_data_in,
//        l/r_data_valid, l/r_data_out, status = {peak[4:0], clip, muted, ramp_busy}.
// Build option: define PEAK_METER_EN to drive status[7:3] with the per-frame peak level; otherwise 0.
module audio_volume_ramp
  import audio_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              mute,
  input  logic [7:0]        volume,
  input  logic [7:0]        ramp_step,
  input  logic              l_data_en,
  input  logic              r_data_en,
  input  logic [DATA_W-1:0] l_data_in,
  input  logic [DATA_W-1:0] r_data_in,
  output logic              l_data_valid,
  output logic              r_data_valid,
  output logic [DATA_W-1:0] l_data_out,
  output logic [DATA_W-1:0] r_data_out,
  output logic [7:0]        status
);

  vr_state_e         state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              clip_q, clip_d;

  logic [GAIN_W-1:0] tgt;
  logic [GAIN_W-1:0] gain_nxt;
  logic              tick;
  logic              l_clip, r_clip;
  logic              ramp_busy, muted;

  // Both channels see gain_q, so samples strobed on a tick use the pre-update gain.
  vol_sat_mult u_left (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .en      (l_data_en),
    .din     (l_data_in),
    .gain    (gain_q),
    .vld     (l_data_valid),
    .dout    (l_data_out),
    .clip    (l_clip)
  );

  vol_sat_mult u_right (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .en      (r_data_en),
    .din     (r_data_in),
    .gain    (gain_q),
    .vld     (r_data_valid),
    .dout    (r_data_out),
    .clip    (r_clip)
  );

  always_comb begin
    tgt      = mute ? '0 : {volume, 8'h00};
    tick     = run & r_data_en;
    gain_nxt = ramp_next(gain_q, tgt, {8'h00, ramp_step});
    gain_d   = gain_q;
    if (!run)      gain_d = '0;
    else if (tick) gain_d = gain_nxt;
    clip_d = run & (clip_q | l_clip | r_clip);
  end

  // Next state follows where the gain lands on this tick, so a retarget
  // mid-ramp (or a zero step) needs no extra cycle.
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = VR_MUTED;
    end else if (tick) begin
      case (state_q)
        VR_MUTED, VR_RAMP, VR_STEADY: begin
          if (gain_nxt != tgt)  state_d = VR_RAMP;
          else if (tgt == '0)   state_d = VR_MUTED;
          else                  state_d = VR_STEADY;
        end
        default: state_d = VR_MUTED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= VR_MUTED;
      gain_q  <= '0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      clip_q  <= clip_d;
    end
  end

  always_comb begin
    ramp_busy = (state_q == VR_RAMP);
    muted     = (gain_q == '0);
  end

`ifdef PEAK_METER_EN
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [4:0]        lvl_q, lvl_d;
  logic [DATA_W-1:0] l_abs, r_abs;

  always_comb begin
    // |PCM_MIN| = 0x800000 is representable as unsigned, so no special case.
    l_abs  = l_data_out[DATA_W-1] ? (~l_data_out + 1'b1) : l_data_out;
    r_abs  = r_data_out[DATA_W-1] ? (~r_data_out + 1'b1) : r_data_out;
    lvl_d  = lvl_q;
    peak_d = tick ? '0 : peak_q;
    if (tick) begin
      lvl_d = '0;
      for (int i = 19; i < DATA_W; i++) begin
        if (peak_q[i]) lvl_d = 5'(i - 19);
      end
    end
    if (l_data_valid && l_abs > peak_d) peak_d = l_abs;
    if (r_data_valid && r_abs > peak_d) peak_d = r_abs;
    if (!run) begin
      peak_d = '0;
      lvl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
      lvl_q  <= '0;
    end else begin
      peak_q <= peak_d;
      lvl_q  <= lvl_d;
    end
  end

  assign status = {lvl_q, clip_q, muted, ramp_busy};
`else
  assign status = {5'b00000, clip_q, muted, ramp_busy};
`endif

endmodule

// File: tb/tb_audio_volume_ramp.sv
module tb_audio_volume_ramp;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        mute;
  logic [7:0]  volume;
  logic [7:0]  ramp_step;
  logic        l_data_en;
  logic        r_data_en;
  logic [23:0] l_data_in;
  logic [23:0] r_data_in;
  logic        l_data_valid;
  logic        r_data_valid;
  logic [23:0] l_data_out;
  logic [23:0] r_data_out;
  logic [7:0]  status;

  int n_tests = 0;
  int n_fail  = 0;

  audio_volume_ramp dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .mute         (mute),
    .volume       (volume),
    .ramp_step    (ramp_step),
    .l_data_en    (l_data_en),
    .r_data_en    (r_data_en),
    .l_data_in    (l_data_in),
    .r_data_in    (r_data_in),
    .l_data_valid (l_data_valid),
    .r_data_valid (r_data_valid),
    .l_data_out   (l_data_out),
    .r_data_out   (r_data_out),
    .status       (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    r_data_in = 24'h000000;
    r_data_en = 1'b1;
    step();
    r_data_en = 1'b0;
  endtask

  // Sample 0x008000 through the left channel: output equals the current gain.
  task automatic probe_gain(output logic [23:0] g);
    l_data_in = 24'h008000;
    l_data_en = 1'b1;
    step();
    l_data_en = 1'b0;
    step();
    g = l_data_out;
  endtask

  function automatic logic [23:0] l_pat(int c);
    return 24'(c * 65536 + 17);
  endfunction

  function automatic logic [23:0] r_pat(int c);
    return 24'(-(c + 1) * 4096);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; mute = 1'b0; volume = 8'h80; ramp_step = 8'h00;
    l_data_en = 1'b0; r_data_en = 1'b0; l_data_in = 24'h123456; r_data_in = 24'h654321;
    for (int i = 0; i < 4; i++) begin
      l_data_en = ~l_data_en; r_data_en = ~r_data_en;
      step();
    end
    n_tests++;
    if ({l_data_valid, r_data_valid, l_data_out, r_data_out} !== 50'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {l_data_valid, r_data_valid, l_data_out, r_data_out});
    end
    n_tests++;
    if (status !== 8'h02) begin
      n_fail++; $display("FAIL reset_status: got %h expected 02", status);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      l_data_en = ~l_data_en; r_data_en = ~r_data_en;
      step();
    end
    l_data_en = 1'b0; r_data_en = 1'b0;
    n_tests++;
    if ({l_data_valid, r_data_valid, l_data_out, r_data_out, status} !== {50'd0, 8'h02}) begin
      n_fail++; $display("FAIL idle_run_low: got %h/%h expected 0/02", {l_data_valid, r_data_valid, l_data_out, r_data_out}, status);
    end
  endtask

  task automatic test_unity();
    volume = 8'h80; ramp_step = 8'h00; mute = 1'b0; run = 1'b1;
    step();
    frame_tick();
    n_tests++;
    if (status !== 8'h00) begin
      n_fail++; $display("FAIL unity_status: got %h expected 00", status);
    end
    l_data_in = 24'h123456; l_data_en = 1'b1;
    step();
    l_data_en = 1'b0;
    n_tests++;
    if (l_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL unity_valid_early: got %b expected 0", l_data_valid);
    end
    step();
    n_tests++;
    if (l_data_valid !== 1'b1 || l_data_out !== 24'h123456) begin
      n_fail++; $display("FAIL unity_out: got %b/%h expected 1/123456", l_data_valid, l_data_out);
    end
    step();
    n_tests++;
    if (l_data_valid !== 1'b0 || l_data_out !== 24'h123456) begin
      n_fail++; $display("FAIL unity_hold: got %b/%h expected 0/123456", l_data_valid, l_data_out);
    end
  endtask

  task automatic test_saturation();
    volume = 8'hFF;
    frame_tick();
    r_data_in = 24'h700000; r_data_en = 1'b1;
    step();
    r_data_en = 1'b0;
    step();
    n_tests++;
    if (r_data_out !== 24'h7FFFFF || status[2] !== 1'b1) begin
      n_fail++; $display("FAIL sat_pos: got %h clip %b expected 7fffff clip 1", r_data_out, status[2]);
    end
    r_data_in = 24'h000100; r_data_en = 1'b1;
    step();
    r_data_en = 1'b0;
    step();
    n_tests++;
    if (r_data_out !== 24'h0001FE || status !== 8'h04) begin
      n_fail++; $display("FAIL clip_sticky: got %h status %h expected 0001fe status 04", r_data_out, status);
    end
    r_data_in = 24'h900000; r_data_en = 1'b1;
    step();
    r_data_en = 1'b0;
    step();
    n_tests++;
    if (r_data_out !== 24'h800000) begin
      n_fail++; $display("FAIL sat_neg: got %h expected 800000", r_data_out);
    end
  endtask

  task automatic test_ramp_up();
    logic [23:0] g;
    run = 1'b0;
    step();
    n_tests++;
    if (status !== 8'h02) begin
      n_fail++; $display("FAIL run_low_clear: got %h expected 02", status);
    end
    run = 1'b1; volume = 8'h80; ramp_step = 8'h80; mute = 1'b0;
    step();
    n_tests++;
    if (status !== 8'h02) begin
      n_fail++; $display("FAIL muted_before_tick: got %h expected 02", status);
    end
    frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h000080 || status !== 8'h01) begin
      n_fail++; $display("FAIL ramp_tick1: got %h status %h expected 000080 status 01", g, status);
    end
    repeat (254) frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h007F80 || status !== 8'h01) begin
      n_fail++; $display("FAIL ramp_tick255: got %h status %h expected 007f80 status 01", g, status);
    end
    frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h008000 || status !== 8'h00) begin
      n_fail++; $display("FAIL ramp_tick256: got %h status %h expected 008000 status 00", g, status);
    end
  endtask

  task automatic test_mute_ramp();
    logic [23:0] g;
    mute = 1'b1;
    frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h007F80 || status !== 8'h01) begin
      n_fail++; $display("FAIL mute_tick1: got %h status %h expected 007f80 status 01", g, status);
    end
    repeat (127) frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h004000) begin
      n_fail++; $display("FAIL mute_midway: got %h expected 004000", g);
    end
    mute = 1'b0;
    frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h004080 || status !== 8'h01) begin
      n_fail++; $display("FAIL mute_reverse: got %h status %h expected 004080 status 01", g, status);
    end
    mute = 1'b1;
    repeat (129) frame_tick();
    n_tests++;
    if (status !== 8'h02) begin
      n_fail++; $display("FAIL mute_done: got %h expected 02", status);
    end
    l_data_in = 24'h400000; l_data_en = 1'b1;
    step();
    l_data_en = 1'b0;
    step();
    n_tests++;
    if (l_data_valid !== 1'b1 || l_data_out !== 24'h000000) begin
      n_fail++; $display("FAIL muted_output: got %b/%h expected 1/000000", l_data_valid, l_data_out);
    end
    mute = 1'b0; volume = 8'h01; ramp_step = 8'hC0;
    frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h0000C0 || status !== 8'h01) begin
      n_fail++; $display("FAIL clamp_up_1: got %h status %h expected 0000c0 status 01", g, status);
    end
    frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h000100 || status !== 8'h00) begin
      n_fail++; $display("FAIL clamp_up_2: got %h status %h expected 000100 status 00", g, status);
    end
    mute = 1'b1;
    frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h000040 || status !== 8'h01) begin
      n_fail++; $display("FAIL clamp_down_1: got %h status %h expected 000040 status 01", g, status);
    end
    frame_tick();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h000000 || status !== 8'h02) begin
      n_fail++; $display("FAIL clamp_down_2: got %h status %h expected 000000 status 02", g, status);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] g;
    int pairs;
    pairs = 0;
    mute = 1'b0; volume = 8'h80; ramp_step = 8'h00;
    frame_tick();
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        l_data_en = 1'b1; r_data_en = 1'b1; l_data_in = l_pat(c); r_data_in = r_pat(c);
      end else begin
        l_data_en = 1'b0; r_data_en = 1'b0;
      end
      step();
      n_tests++;
      if (c >= 1 && c <= 8) begin
        if (l_data_valid !== 1'b1 || r_data_valid !== 1'b1 ||
            l_data_out !== l_pat(c - 1) || r_data_out !== r_pat(c - 1)) begin
          n_fail++;
          $display("FAIL b2b_pair%0d: got %b%b %h %h expected 11 %h %h", c - 1,
                   l_data_valid, r_data_valid, l_data_out, r_data_out, l_pat(c - 1), r_pat(c - 1));
        end else begin
          pairs++;
        end
      end else if (l_data_valid !== 1'b0 || r_data_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_idle%0d: got %b%b expected 00", c, l_data_valid, r_data_valid);
      end
    end
    n_tests++;
    if (pairs !== 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 8", pairs);
    end
    l_data_en = 1'b1; r_data_en = 1'b1; l_data_in = 24'h111111; r_data_in = 24'h222222;
    repeat (3) step();
    run = 1'b0;
    step();
    n_tests++;
    if ({l_data_valid, r_data_valid, l_data_out, r_data_out} !== 50'd0 || status !== 8'h02) begin
      n_fail++; $display("FAIL run_drop: got %h status %h expected 0 status 02",
                         {l_data_valid, r_data_valid, l_data_out, r_data_out}, status);
    end
    l_data_en = 1'b0; r_data_en = 1'b0; run = 1'b1;
    step();
    probe_gain(g);
    n_tests++;
    if (g !== 24'h000000) begin
      n_fail++; $display("FAIL run_drop_gain: got %h expected 000000", g);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_saturation();
    test_ramp_up();
    test_mute_ramp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
